// File: rtl/pipe_core_fwd_if.sv
// Fetch/retire bus of the 4-stage forwarding core: instruction memory port plus
// the writeback, hazard and forwarding status outputs.
interface pipe_core_fwd_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned PC_W   = 8
);
    localparam int unsigned INSTR_W = 4 + 3 * RA_W + DATA_W;

    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  alu_out;
    logic               wb_valid;
    logic [RA_W-1:0]    wb_rd;
    logic               stall;
    logic               halted;
    logic               fwd_a;
    logic               fwd_b;

    modport master (
        input  instr,
        output pc, alu_out, wb_valid, wb_rd, stall, halted, fwd_a, fwd_b
    );

    modport slave (
        output instr,
        input  pc, alu_out, wb_valid, wb_rd, stall, halted, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_core_fwd.sv
// 4-stage in-order integer pipeline (IF/ID/EX/WB) with register file, EX operand
// forwarding, ID write-through bypass, multi-cycle MUL stall and sticky HALT.
module pipe_core_fwd #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RA_W    = 3,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rstn,
    pipe_core_fwd_if.master bus
);
    localparam int unsigned INSTR_W = 4 + 3 * RA_W + DATA_W;
    localparam int unsigned NREG    = 1 << RA_W;
    localparam int unsigned CNT_W   = $clog2(MUL_LAT + 1);
    // Counter value on the last stall cycle; unused when MUL_LAT == 1.
    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(MUL_LAT - 2);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    // Fetch and IF/ID
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               halt_seen_q, halt_seen_d;

    // ID/EX
    logic               idex_valid_q, idex_valid_d;
    logic [3:0]         idex_op_q, idex_op_d;
    logic [RA_W-1:0]    idex_rd_q, idex_rd_d;
    logic [RA_W-1:0]    idex_rs1_q, idex_rs1_d;
    logic [RA_W-1:0]    idex_rs2_q, idex_rs2_d;
    logic [DATA_W-1:0]  idex_imm_q, idex_imm_d;
    logic [DATA_W-1:0]  idex_a_q, idex_a_d;
    logic [DATA_W-1:0]  idex_b_q, idex_b_d;
    logic               fwd_a_q, fwd_a_d;
    logic               fwd_b_q, fwd_b_d;

    // MUL sequencing
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic               stall_q, stall_d;
    logic [DATA_W-1:0]  mul_a_q, mul_a_d;
    logic [DATA_W-1:0]  mul_b_q, mul_b_d;

    // EX/WB and retirement
    logic [DATA_W-1:0]  alu_out_q, alu_out_d;
    logic               wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]    wb_rd_q, wb_rd_d;
    logic               wb_halt_q, wb_halt_d;
    logic               halted_q, halted_d;

    logic [DATA_W-1:0]  rf_q [NREG];
    logic [DATA_W-1:0]  rf_d [NREG];

    // ID decode and register read with same-cycle writeback bypass
    logic [3:0]         id_op;
    logic [RA_W-1:0]    id_rd, id_rs1, id_rs2;
    logic [DATA_W-1:0]  id_imm, id_a, id_b;
    logic               id_is_halt;

    always_comb begin
        {id_op, id_rd, id_rs1, id_rs2, id_imm} = ifid_instr_q;
        id_is_halt = ifid_valid_q && (id_op == OP_HALT);

        if (id_rs1 == '0)
            id_a = '0;
        else if (wb_valid_q && (wb_rd_q == id_rs1))
            id_a = alu_out_q;
        else
            id_a = rf_q[id_rs1];

        if (id_rs2 == '0)
            id_b = '0;
        else if (wb_valid_q && (wb_rd_q == id_rs2))
            id_b = alu_out_q;
        else
            id_b = rf_q[id_rs2];
    end

    // EX operand select, MUL operand capture and ALU
    logic [DATA_W-1:0]  op_a, op_b, mul_src_a, mul_src_b, ex_result;
    logic               ex_is_mul, mul_first, ex_writes, ex_is_halt;

    always_comb begin
        op_a       = fwd_a_q ? alu_out_q : idex_a_q;
        op_b       = fwd_b_q ? alu_out_q : idex_b_q;
        ex_is_mul  = idex_valid_q && (idex_op_q == OP_MUL);
        mul_first  = ex_is_mul && (mul_cnt_q == '0);
        mul_src_a  = mul_first ? op_a : mul_a_q;
        mul_src_b  = mul_first ? op_b : mul_b_q;
        ex_is_halt = idex_valid_q && (idex_op_q == OP_HALT);
        ex_writes  = idex_valid_q && (idex_op_q >= OP_ADD) && (idex_op_q <= OP_MUL)
                     && (idex_rd_q != '0);

        ex_result = '0;
        case (idex_op_q)
            OP_ADD:  ex_result = op_a + op_b;
            OP_SUB:  ex_result = op_a - op_b;
            OP_AND:  ex_result = op_a & op_b;
            OP_OR:   ex_result = op_a | op_b;
            OP_XOR:  ex_result = op_a ^ op_b;
            OP_LDI:  ex_result = idex_imm_q;
            OP_MUL:  ex_result = mul_src_a * mul_src_b;
            default: ex_result = '0;
        endcase
    end

    // Pipeline advance, hazard control and next-cycle forwarding selects
    always_comb begin
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        halt_seen_d  = halt_seen_q;
        idex_valid_d = idex_valid_q;
        idex_op_d    = idex_op_q;
        idex_rd_d    = idex_rd_q;
        idex_rs1_d   = idex_rs1_q;
        idex_rs2_d   = idex_rs2_q;
        idex_imm_d   = idex_imm_q;
        idex_a_d     = idex_a_q;
        idex_b_d     = idex_b_q;
        mul_cnt_d    = mul_cnt_q;
        stall_d      = stall_q;
        mul_a_d      = mul_first ? op_a : mul_a_q;
        mul_b_d      = mul_first ? op_b : mul_b_q;
        alu_out_d    = alu_out_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_halt_d    = 1'b0;
        halted_d     = halted_q | wb_halt_q;

        if (stall_q) begin
            // MUL still iterating: front of the pipe holds, EX/WB takes a bubble.
            mul_cnt_d = mul_cnt_q + CNT_W'(1);
            stall_d   = (mul_cnt_q != LAST_STALL);
        end else begin
            mul_cnt_d  = '0;
            wb_valid_d = ex_writes;
            wb_halt_d  = ex_is_halt;
            if (ex_writes) begin
                alu_out_d = ex_result;
                wb_rd_d   = idex_rd_q;
            end

            idex_valid_d = ifid_valid_q;
            idex_op_d    = id_op;
            idex_rd_d    = id_rd;
            idex_rs1_d   = id_rs1;
            idex_rs2_d   = id_rs2;
            idex_imm_d   = id_imm;
            idex_a_d     = id_a;
            idex_b_d     = id_b;
            stall_d      = ifid_valid_q && (id_op == OP_MUL) && (MUL_LAT > 1);

            // Once HALT reaches ID, fetch stops for good and IF/ID fills with bubbles.
            if (halt_seen_q || id_is_halt) begin
                halt_seen_d  = 1'b1;
                ifid_valid_d = 1'b0;
                ifid_instr_d = '0;
            end else begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = bus.instr;
                pc_d         = pc_q + PC_W'(1);
            end
        end

        fwd_a_d = wb_valid_d && (wb_rd_d == idex_rs1_d) && (idex_rs1_d != '0);
        fwd_b_d = wb_valid_d && (wb_rd_d == idex_rs2_d) && (idex_rs2_d != '0);
    end

    // Register file write from EX/WB
    always_comb begin
        rf_d = rf_q;
        if (wb_valid_q)
            rf_d[wb_rd_q] = alu_out_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            halt_seen_q  <= 1'b0;
            idex_valid_q <= 1'b0;
            idex_op_q    <= OP_NOP;
            idex_rd_q    <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_imm_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            mul_cnt_q    <= '0;
            stall_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            alu_out_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_halt_q    <= 1'b0;
            halted_q     <= 1'b0;
            rf_q         <= '{default: '0};
        end else begin
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            halt_seen_q  <= halt_seen_d;
            idex_valid_q <= idex_valid_d;
            idex_op_q    <= idex_op_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs1_q   <= idex_rs1_d;
            idex_rs2_q   <= idex_rs2_d;
            idex_imm_q   <= idex_imm_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            mul_cnt_q    <= mul_cnt_d;
            stall_q      <= stall_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            alu_out_q    <= alu_out_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_halt_q    <= wb_halt_d;
            halted_q     <= halted_d;
            rf_q         <= rf_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.alu_out  = alu_out_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.stall    = stall_q;
    assign bus.halted   = halted_q;
    assign bus.fwd_a    = fwd_a_q;
    assign bus.fwd_b    = fwd_b_q;
endmodule

// File: tb/tb_pipe_core_fwd.sv
// Bench for pipe_core_fwd: directed timing scenarios plus random programs checked
// against a sequential ISA model of the retire stream.
module tb_pipe_core_fwd;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RA_W    = 3;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned INSTR_W = 4 + 3 * RA_W + DATA_W;
    localparam int unsigned IMEM_N  = 1 << PC_W;

    typedef struct packed {
        logic [RA_W-1:0]   rd;
        logic [DATA_W-1:0] val;
    } wb_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    pipe_core_fwd_if #(.DATA_W(DATA_W), .RA_W(RA_W), .PC_W(PC_W)) bus ();

    pipe_core_fwd #(
        .DATA_W(DATA_W), .RA_W(RA_W), .PC_W(PC_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    logic [INSTR_W-1:0] imem [IMEM_N];
    assign bus.instr = imem[bus.pc];

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-edge snapshots, index = edge number after reset release
    logic [PC_W-1:0]   h_pc    [64];
    logic [DATA_W-1:0] h_alu   [64];
    logic              h_wbv   [64];
    logic [RA_W-1:0]   h_rd    [64];
    logic              h_stall [64];
    logic              h_halt  [64];
    logic              h_fa    [64];
    logic              h_fb    [64];

    wb_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] enc(input int unsigned op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned imm);
        enc = {4'(op), RA_W'(rd), RA_W'(rs1), RA_W'(rs2), DATA_W'(imm)};
    endfunction

    task automatic begin_test();
        rstn = 1'b0;
        for (int i = 0; i < IMEM_N; i++) imem[i] = '0;
    endtask

    task automatic go(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_pc"},     bus.pc, 0);
        chk({tag, "_rst_alu"},    bus.alu_out, 0);
        chk({tag, "_rst_wbv"},    bus.wb_valid, 0);
        chk({tag, "_rst_stall"},  bus.stall, 0);
        chk({tag, "_rst_halted"}, bus.halted, 0);
        chk({tag, "_rst_fwd"},    {bus.fwd_a, bus.fwd_b}, 0);
        rstn = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            h_pc[i]    = bus.pc;
            h_alu[i]   = bus.alu_out;
            h_wbv[i]   = bus.wb_valid;
            h_rd[i]    = bus.wb_rd;
            h_stall[i] = bus.stall;
            h_halt[i]  = bus.halted;
            h_fa[i]    = bus.fwd_a;
            h_fb[i]    = bus.fwd_b;
        end
    endtask

    initial begin
        // 1: reset and free-running fetch
        begin_test();
        go("t1");
        run(3);
        chk("t1_pc1", h_pc[1], 1);
        chk("t1_pc2", h_pc[2], 2);
        chk("t1_pc3", h_pc[3], 3);

        // 2: back-to-back RAW, then read r4 back from the register file
        begin_test();
        imem[0] = enc(6, 1, 0, 0, 5);
        imem[1] = enc(6, 2, 0, 0, 3);
        imem[2] = enc(1, 3, 1, 2, 0);
        imem[3] = enc(2, 4, 3, 1, 0);
        imem[8] = enc(1, 5, 4, 0, 0);
        go("t2");
        run(11);
        chk("t2_alu_e3", h_alu[3], 5);
        chk("t2_alu_e4", h_alu[4], 3);
        chk("t2_alu_e5", h_alu[5], 8);
        chk("t2_alu_e6", h_alu[6], 3);
        chk("t2_rd_e6",  h_rd[6], 4);
        chk("t2_add_fwd", {h_fa[4], h_fb[4]}, 2'b01);
        chk("t2_sub_fwd", {h_fa[5], h_fb[5]}, 2'b10);
        chk("t2_r4_alu", h_alu[11], 3);
        chk("t2_r4_rd",  h_rd[11], 5);
        chk("t2_r4_wbv", h_wbv[11], 1);

        // 3: distance-2 dependence served by the ID bypass
        begin_test();
        imem[0] = enc(6, 1, 0, 0, 200);
        imem[2] = enc(1, 2, 1, 1, 0);
        go("t3");
        run(5);
        chk("t3_nop_wbv", h_wbv[4], 0);
        chk("t3_fwd",     {h_fa[4], h_fb[4]}, 0);
        chk("t3_alu",     h_alu[5], 144);
        chk("t3_rd",      h_rd[5], 2);

        // 4: MUL stall and product forwarding
        begin_test();
        imem[0] = enc(6, 1, 0, 0, 7);
        imem[1] = enc(6, 2, 0, 0, 6);
        imem[2] = enc(7, 3, 1, 2, 0);
        imem[3] = enc(1, 4, 3, 1, 0);
        go("t4");
        run(8);
        chk("t4_stall_e3", h_stall[3], 0);
        chk("t4_stall_e4", h_stall[4], 1);
        chk("t4_stall_e5", h_stall[5], 1);
        chk("t4_stall_e6", h_stall[6], 0);
        chk("t4_pc_e4", h_pc[4], 4);
        chk("t4_pc_e5", h_pc[5], 4);
        chk("t4_pc_e6", h_pc[6], 4);
        chk("t4_pc_e7", h_pc[7], 5);
        chk("t4_bubble", {h_wbv[5], h_wbv[6]}, 0);
        chk("t4_mul", h_alu[7], 42);
        chk("t4_add_fwd", h_fa[7], 1);
        chk("t4_add", h_alu[8], 49);

        // 5: r0 is never written nor forwarded
        begin_test();
        imem[0] = enc(6, 0, 0, 0, 9);
        imem[1] = enc(1, 1, 0, 0, 0);
        go("t5");
        run(4);
        chk("t5_ldi_wbv", h_wbv[3], 0);
        chk("t5_ldi_alu", h_alu[3], 0);
        chk("t5_fwd",     {h_fa[3], h_fb[3]}, 0);
        chk("t5_add_alu", h_alu[4], 0);
        chk("t5_add_rd",  {h_wbv[4], h_rd[4]}, {1'b1, 3'd1});

        // 6a: HALT retires, younger instruction never executes
        begin_test();
        imem[0] = enc(6, 1, 0, 0, 1);
        imem[1] = enc(8, 0, 0, 0, 0);
        imem[2] = enc(6, 1, 0, 0, 2);
        go("t6");
        run(10);
        chk("t6_halted_e4", h_halt[4], 0);
        chk("t6_halted_e5", h_halt[5], 1);
        chk("t6_halted_e10", h_halt[10], 1);
        chk("t6_pc_e3", h_pc[3], 2);
        chk("t6_pc_e10", h_pc[10], 2);
        for (int i = 4; i <= 10; i++) chk("t6_no_wb", h_wbv[i], 0);
        chk("t6_alu", h_alu[10], 1);

        // 6b: reset in the second MUL stall cycle
        begin_test();
        imem[0] = enc(6, 1, 0, 0, 7);
        imem[1] = enc(6, 2, 0, 0, 6);
        imem[2] = enc(7, 3, 1, 2, 0);
        go("t6b");
        run(5);
        chk("t6b_stall_pre", {h_stall[4], h_stall[5]}, 2'b11);
        rstn = 1'b0;
        #1;
        chk("t6b_stall", bus.stall, 0);
        chk("t6b_halted", bus.halted, 0);
        chk("t6b_pc", bus.pc, 0);
        chk("t6b_alu", bus.alu_out, 0);
        chk("t6b_wbv", bus.wb_valid, 0);
        begin_test();
        imem[0] = enc(1, 5, 3, 1, 0);
        go("t6c");
        run(3);
        chk("t6c_rf_cleared", h_alu[3], 0);
        chk("t6c_wb", {h_wbv[3], h_rd[3]}, {1'b1, 3'd5});

        // Random programs against a sequential ISA model
        for (int p = 0; p < 4; p++) begin
            int unsigned regs [8];
            int unsigned nmul, h, ncyc, nstall;
            wb_t e;
            begin_test();
            exp_q.delete();
            for (int r = 0; r < 8; r++) regs[r] = 0;
            nmul = 0;
            h = 0;
            for (int i = 0; i < 40; i++) begin
                int unsigned op, rd, rs1, rs2, imm, a, b, res;
                op  = $urandom_range(0, 15);
                if (op == 8) op = 7;
                rd  = $urandom_range(0, 4);
                rs1 = $urandom_range(0, 4);
                rs2 = $urandom_range(0, 4);
                imm = $urandom_range(0, 255);
                imem[h] = enc(op, rd, rs1, rs2, imm);
                h++;
                a = regs[rs1];
                b = regs[rs2];
                case (op)
                    1: res = (a + b) % 256;
                    2: res = (a + 256 - b) % 256;
                    3: res = a & b;
                    4: res = a | b;
                    5: res = a ^ b;
                    6: res = imm;
                    7: res = (a * b) % 256;
                    default: res = 0;
                endcase
                if (op == 7) nmul++;
                if (op >= 1 && op <= 7 && rd != 0) begin
                    regs[rd] = res;
                    exp_q.push_back({RA_W'(rd), DATA_W'(res)});
                end
            end
            for (int r = 1; r < 8; r++) begin
                imem[h] = enc(1, r, r, 0, 0);
                h++;
                exp_q.push_back({RA_W'(r), DATA_W'(regs[r])});
            end
            imem[h] = enc(8, 0, 0, 0, 0);
            for (int k = 1; k <= 3; k++) imem[h + k] = enc(6, 1, 0, 0, 170);
            go("rnd");
            ncyc = 0;
            nstall = 0;
            while (!bus.halted && ncyc < 400) begin
                @(posedge clk);
                #1;
                ncyc++;
                if (bus.stall) nstall++;
                if (bus.wb_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_extra_wb", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rnd_wb_rd",  bus.wb_rd, e.rd);
                        chk("rnd_wb_val", bus.alu_out, e.val);
                    end
                end
            end
            chk("rnd_halted",     bus.halted, 1);
            chk("rnd_halt_cycle", ncyc, h + 4 + nmul * (MUL_LAT - 1));
            chk("rnd_stalls",     nstall, nmul * (MUL_LAT - 1));
            chk("rnd_pending",    exp_q.size(), 0);
            chk("rnd_pc",         bus.pc, h + 1);
            repeat (4) begin
                @(posedge clk);
                #1;
                chk("rnd_post_halt_wbv", bus.wb_valid, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_core_fwd.md
Name: pipe_core_fwd

Overview:
- Parametrised 4-stage in-order integer pipeline (IF/ID/EX/WB) with a register file, full operand forwarding, ID-stage write-through bypass, and hazard control.
- Hazard control covers a multi-cycle MUL (EX stall) and a HALT instruction.
- Successor to the fixed 8-bit single-forward core: operands come from register addresses instead of immediates, and hazards are detected per register.
- Instruction memory is external with asynchronous read, indexed by pc.

Parameters:
DATA_W, 8, datapath and register width
RA_W, 3, register address width (2**RA_W registers, r0 reads zero)
PC_W, 8, program counter width
MUL_LAT, 3, EX cycles for MUL (>=1)
INSTR_W, 4+3*RA_W+DATA_W, derived; fields {opcode[3:0], rd, rs1, rs2, imm}, MSB first

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
instr  in  INSTR_W  instruction at address pc, combinational from external memory
pc  out  PC_W  fetch address
alu_out  out  DATA_W  EX/WB result register
wb_valid  out  1  EX/WB holds a writing instruction this cycle
wb_rd  out  RA_W  EX/WB destination register
stall  out  1  upstream hold due to multi-cycle MUL
halted  out  1  HALT has retired; sticky until reset
fwd_a  out  1  EX operand A taken from EX/WB this cycle
fwd_b  out  1  EX operand B taken from EX/WB this cycle

Behaviour:
- Reset (async, rstn=0): pc=0, all pipeline valids=0, regfile all 0, MUL counter=0, alu_out=0, wb_valid=0, wb_rd=0, stall=0, halted=0, fwd_a=fwd_b=0.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI rd=imm
  - 7 MUL rd=low DATA_W bits of rs1*rs2
  - 8 HALT
  - 9-15 treated as NOP
- All arithmetic is modulo 2**DATA_W with no flags. NOP, HALT and unknown opcodes never write.
- Flow: IF/ID captures instr at each unstalled edge; ID reads the regfile; EX computes; the EX/WB register writes the regfile on the next edge.
- Latency: fetch edge to regfile update is 3 edges; alu_out is valid 2 edges after fetch (ALU ops, MUL_LAT=1).
- pc increments by 1 per unstalled, unhalted edge and wraps from 2**PC_W-1 to 0.
- Forwarding in EX: operand A = EX/WB result if wb_valid && wb_rd==rs1_ex && rs1_ex!=0, else the ID/EX value. Operand B uses the same rule with rs2. fwd_a and fwd_b reflect these selects.
- ID bypass: if the WB write address equals an ID source (nonzero), ID takes the write data in the same cycle.
- r0: always reads 0; writes to r0 are dropped and never forwarded, and wb_valid=0 for them.
- MUL stall:
  - On the first EX cycle, forwarded operands are latched into local operand registers.
  - If MUL_LAT>1, stall=1 for MUL_LAT-1 cycles. During the stall, pc, IF/ID and ID/EX hold and EX/WB loads a bubble (wb_valid=0).
  - On the final cycle the product loads into EX/WB.
  - A dependent instruction directly behind the MUL then forwards the product normally.
  - Back-to-back MULs each stall independently.
- HALT:
  - When ID holds HALT, pc freezes at the next edge, IF/ID loads a bubble, and HALT proceeds down the pipe.
  - Instructions older than HALT complete.
  - halted=1 the cycle after HALT leaves EX/WB.
  - Once halted, no further fetch; exit is by reset only.
  - A stall takes priority over HALT in ID; HALT waits in ID.
- Reset mid-MUL or mid-HALT: everything returns to reset values immediately, with no partial writeback.
- Simultaneous WB write and ID read of the same register: ID sees the new value.

Test Plan:
1. Reset: hold rstn=0 with clocks running -> pc=0, alu_out=0, wb_valid=0, stall=0, halted=0; release -> pc counts 1,2,3 on successive edges.
2. Back-to-back RAW: LDI r1,5; LDI r2,3; ADD r3,r1,r2; SUB r4,r3,r1 -> fwd_a=1 on the SUB cycle, alu_out sequence 5,3,8,3, r4=3.
3. Distance-2 via bypass: LDI r1,200; NOP; ADD r2,r1,r1 -> fwd_a=fwd_b=0 for the ADD, alu_out=144 (400 mod 256).
4. MUL stall, MUL_LAT=3: LDI r1,7; LDI r2,6; MUL r3,r1,r2; ADD r4,r3,r1 -> stall=1 for exactly 2 cycles, pc frozen, alu_out=42 then 49.
5. r0 guard: LDI r0,9; ADD r1,r0,r0 -> wb_valid=0 for the LDI, fwd_a=0, r1=0.
6. HALT and reset: LDI r1,1; HALT; LDI r1,2 -> r1 stays 1, pc frozen, halted=1. Then assert rstn=0 during the 2nd stall cycle of a MUL -> stall=0, halted=0, pc=0 immediately.
